// File: rtl/acc_core_fsm_if.sv
// acc_core_fsm_if: memory req/ack bus and word I/O valid/ready ports of the accumulator core
interface acc_core_fsm_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, in_ready, out_data, out_valid,
    input  mem_rdata, mem_ack, in_data, in_valid, out_ready
  );
  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, in_ready, out_data, out_valid,
    output mem_rdata, mem_ack, in_data, in_valid, out_ready
  );
endinterface

// File: rtl/acc_core_fsm.sv
// acc_core_fsm: multicycle fetch-decode-execute accumulator core; ACC_OVF_FLAG_EN adds a sticky signed-overflow flag
module acc_core_fsm #(
  parameter int          DATA_W   = 16,
  parameter int          ADDR_W   = 12,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              reset,
  acc_core_fsm_if.master    bus,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] ac,
  output logic              halted,
  output logic              illegal
`ifdef ACC_OVF_FLAG_EN
  ,
  output logic              ovf
`endif
);
  typedef enum logic [3:0] {FETCH, DECODE, RD_IND, RD_OP, EXEC, WR, IO_IN, IO_OUT, HALT} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, mar_q, mar_d;
  logic [DATA_W-1:0] ac_q, ac_d, mbr_q, mbr_d, ir_q, ir_d, out_q, out_d;
  logic              ill_q, ill_d;
`ifdef ACC_OVF_FLAG_EN
  logic              ovf_q, ovf_d;
`endif
  logic [3:0]        op;
  logic [ADDR_W-1:0] addr;
  logic [1:0]        cond;
  logic              skip;
  logic [DATA_W-1:0] sum, dif;
  logic              unused_ir;
  assign op        = ir_q[DATA_W-1 -: 4];
  assign addr      = ir_q[ADDR_W-1:0];
  assign cond      = ir_q[ADDR_W-1 -: 2];
  assign unused_ir = ^ir_q;
  assign sum       = ac_q + mbr_q;
  assign dif       = ac_q - mbr_q;
  assign skip      = cond == 2'b00 ? ac_q[DATA_W-1] :
                     cond == 2'b01 ? ac_q == '0 :
                     cond == 2'b10 ? !ac_q[DATA_W-1] && ac_q != '0 : 1'b0;
  // state and architectural registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FETCH;
      pc_q    <= ADDR_W'(RESET_PC);
      ac_q    <= '0;
      mar_q   <= '0;
      mbr_q   <= '0;
      ir_q    <= '0;
      out_q   <= '0;
      ill_q   <= 1'b0;
`ifdef ACC_OVF_FLAG_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ac_q    <= ac_d;
      mar_q   <= mar_d;
      mbr_q   <= mbr_d;
      ir_q    <= ir_d;
      out_q   <= out_d;
      ill_q   <= ill_d;
`ifdef ACC_OVF_FLAG_EN
      ovf_q   <= ovf_d;
`endif
    end
  end
  // next state and register updates; acks only matter in states that drive mem_req
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ac_d    = ac_q;
    mar_d   = mar_q;
    mbr_d   = mbr_q;
    ir_d    = ir_q;
    out_d   = out_q;
    ill_d   = ill_q;
`ifdef ACC_OVF_FLAG_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      FETCH: if (bus.mem_ack) begin
        ir_d    = bus.mem_rdata;
        pc_d    = pc_q + 1'b1;
        state_d = DECODE;
      end
      DECODE: begin
        mar_d = addr;
        case (op)
          4'h0: begin mbr_d = DATA_W'(pc_q); state_d = WR; end
          4'h1, 4'h3, 4'h4, 4'hD: state_d = RD_OP;
          4'h2: begin mbr_d = ac_q; state_d = WR; end
          4'h5: state_d = IO_IN;
          4'h6: begin out_d = ac_q; state_d = IO_OUT; end
          4'h7: state_d = HALT;
          4'h8: begin pc_d = skip ? pc_q + 1'b1 : pc_q; state_d = FETCH; end
          4'h9: begin pc_d = addr; state_d = FETCH; end
          4'hA: begin
            ac_d    = '0;
`ifdef ACC_OVF_FLAG_EN
            ovf_d   = 1'b0;
`endif
            state_d = FETCH;
          end
          4'hB, 4'hC: state_d = RD_IND;
          default: begin ill_d = 1'b1; state_d = HALT; end
        endcase
      end
      RD_IND: if (bus.mem_ack) begin
        pc_d    = op == 4'hC ? bus.mem_rdata[ADDR_W-1:0] : pc_q;
        mar_d   = op == 4'hC ? mar_q : bus.mem_rdata[ADDR_W-1:0];
        state_d = op == 4'hC ? FETCH : RD_OP;
      end
      RD_OP: if (bus.mem_ack) begin
        mbr_d   = bus.mem_rdata;
        state_d = EXEC;
      end
      EXEC: begin
        ac_d    = op == 4'h1 ? mbr_q : op == 4'h4 ? dif : op == 4'hD ? ac_q & mbr_q : sum;
`ifdef ACC_OVF_FLAG_EN
        if ((op == 4'h3 || op == 4'hB) && ac_q[DATA_W-1] == mbr_q[DATA_W-1] && sum[DATA_W-1] != ac_q[DATA_W-1])
          ovf_d = 1'b1;
        if (op == 4'h4 && ac_q[DATA_W-1] != mbr_q[DATA_W-1] && dif[DATA_W-1] != ac_q[DATA_W-1])
          ovf_d = 1'b1;
`endif
        state_d = FETCH;
      end
      WR: if (bus.mem_ack) begin
        pc_d    = op == 4'h0 ? mar_q + 1'b1 : pc_q;
        state_d = FETCH;
      end
      IO_IN: if (bus.in_valid) begin
        ac_d    = bus.in_data;
        state_d = FETCH;
      end
      IO_OUT: if (bus.out_ready) state_d = FETCH;
      default: ;
    endcase
  end
  // strobes and visible state; mem_req is gated by reset so it drops the instant reset asserts
  always_comb begin
    bus.mem_req   = reset && (state_q == FETCH || state_q == RD_IND || state_q == RD_OP || state_q == WR);
    bus.mem_we    = state_q == WR;
    bus.mem_addr  = state_q == FETCH ? pc_q : mar_q;
    bus.mem_wdata = mbr_q;
    bus.in_ready  = state_q == IO_IN;
    bus.out_valid = state_q == IO_OUT;
    bus.out_data  = out_q;
    halted        = state_q == HALT;
    pc            = pc_q;
    ac            = ac_q;
    illegal       = ill_q;
`ifdef ACC_OVF_FLAG_EN
    ovf           = ovf_q;
`endif
  end
endmodule
